// File: rtl/cnn_stage_sequencer.sv
// cnn_stage_sequencer: flushes the CNN chain, then releases each stage in order on the
// previous stage's done flag, with a per-stage watchdog, class latch and latency capture.
module cnn_stage_sequencer #(
    parameter int NUM_STAGES     = 5,
    parameter int FLUSH_CYCLES   = 2,
    parameter int LAST_LAT       = 2,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TMO_W          = 16,
    parameter int LAT_W          = 20,
    parameter int CLASS_W        = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NUM_STAGES-2:0] stage_done,
    input  logic [CLASS_W-1:0]    class_in,
    output logic [NUM_STAGES-1:0] stage_rst_n,
    output logic                  busy,
    output logic                  done,
    output logic [CLASS_W-1:0]    class_out,
    output logic                  timeout_err,
    output logic [2:0]            err_stage,
    output logic [2:0]            cur_stage,
    output logic [LAT_W-1:0]      latency
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FLUSH = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_TAIL  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [2:0]            idx_q, idx_d;
    logic [TMO_W-1:0]      cnt_q, cnt_d;
    logic [NUM_STAGES-1:0] rst_n_q, rst_n_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [CLASS_W-1:0]    class_q, class_d;
    logic                  tmo_q, tmo_d;
    logic [2:0]            err_q, err_d;
    logic [LAT_W-1:0]      lat_q, lat_d;
    logic [LAT_W-1:0]      latency_q, latency_d;
    logic [LAT_W-1:0]      lat_nxt;
    logic                  done_hit;

    // only the awaited stage's done flag matters; the rest are masked off
    assign done_hit = |(stage_done & ((NUM_STAGES-1)'(1) << idx_q));
    assign lat_nxt  = (&lat_q) ? lat_q : lat_q + LAT_W'(1);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        rst_n_d   = rst_n_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        class_d   = class_q;
        tmo_d     = tmo_q;
        err_d     = err_q;
        lat_d     = busy_q ? lat_nxt : lat_q;
        latency_d = latency_q;
        if (abort) begin
            state_d = S_IDLE;
            idx_d   = '0;
            rst_n_d = '0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_ERR: if (start) begin
                    state_d = S_FLUSH;
                    busy_d  = 1'b1;
                    tmo_d   = 1'b0;
                    err_d   = '0;
                    lat_d   = '0;
                    cnt_d   = '0;
                end
                S_FLUSH: if (cnt_q == TMO_W'(FLUSH_CYCLES-1)) begin
                    state_d = S_RUN;
                    idx_d   = '0;
                    cnt_d   = '0;
                    rst_n_d = NUM_STAGES'(1);
                end else begin
                    cnt_d = cnt_q + TMO_W'(1);
                end
                S_RUN: if (done_hit) begin
                    rst_n_d = rst_n_q | (NUM_STAGES'(2) << idx_q);
                    idx_d   = idx_q + 3'd1;
                    cnt_d   = '0;
                    state_d = (idx_q == 3'(NUM_STAGES-2)) ? S_TAIL : S_RUN;
                end else if (cnt_q == TMO_W'(TIMEOUT_CYCLES-1)) begin
                    state_d = S_ERR;
                    tmo_d   = 1'b1;
                    err_d   = idx_q;
                    idx_d   = '0;
                    rst_n_d = '0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + TMO_W'(1);
                end
                S_TAIL: if (cnt_q == TMO_W'(LAST_LAT-1)) begin
                    state_d   = S_IDLE;
                    idx_d     = '0;
                    class_d   = class_in;
                    done_d    = 1'b1;
                    latency_d = lat_nxt;
                    rst_n_d   = '0;
                    busy_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + TMO_W'(1);
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            rst_n_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            class_q   <= '0;
            tmo_q     <= 1'b0;
            err_q     <= '0;
            lat_q     <= '0;
            latency_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            rst_n_q   <= rst_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            class_q   <= class_d;
            tmo_q     <= tmo_d;
            err_q     <= err_d;
            lat_q     <= lat_d;
            latency_q <= latency_d;
        end
    end

    assign stage_rst_n = rst_n_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign class_out   = class_q;
    assign timeout_err = tmo_q;
    assign err_stage   = err_q;
    assign cur_stage   = idx_q;
    assign latency     = latency_q;
endmodule
